// File: rtl/burst_addr_gen.sv
// burst_addr_gen: multi-lane read/write address generator.
// A start request latches bases, stride, beat count and an optional
// circular-addressing window. The block then emits one beat per accepted
// handshake. Each beat carries LANES read and LANES write addresses.
module burst_addr_gen #(
  parameter int ADDR_W  = 32,
  parameter int LANES   = 16,
  parameter int CNT_W   = 16,
  parameter int WRAP_LW = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [ADDR_W-1:0]         rd_base,
  input  logic [ADDR_W-1:0]         wr_base,
  input  logic [ADDR_W-1:0]         stride,
  input  logic [CNT_W-1:0]          count,
  input  logic                      wrap_en,
  input  logic [WRAP_LW-1:0]        wrap_log2,
  input  logic                      ready,
  output logic                      valid,
  output logic [LANES*ADDR_W-1:0]   rd_addr,
  output logic [LANES*ADDR_W-1:0]   wr_addr,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic [ADDR_W-1:0]    rd_base_q;
  logic [ADDR_W-1:0]    wr_base_q;
  logic [ADDR_W-1:0]    stride_q;
  logic [ADDR_W-1:0]    step_q;     // LANES*stride, the per-beat offset advance
  logic [ADDR_W-1:0]    offset_q;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     beat_q;
  logic                 wrap_en_q;
  logic [WRAP_LW-1:0]   wrap_log2_q;
  logic [ADDR_W-1:0]    mask;
  logic [ADDR_W-1:0]    lane_off;

  // Window mask for circular addressing; a window as wide as the address
  // space (or wider) leaves every bit alone.
  function automatic logic [ADDR_W-1:0] wrap_mask(input logic en,
                                                  input logic [WRAP_LW-1:0] lw);
    logic [ADDR_W-1:0] m;
    if (!en || (int'(lw) >= ADDR_W))
      m = {ADDR_W{1'b1}};
    else
      m = ~({ADDR_W{1'b1}} << lw);
    return m;
  endfunction

  // Control FSM plus latched configuration and the running beat offset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      valid       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_base_q   <= '0;
      wr_base_q   <= '0;
      stride_q    <= '0;
      step_q      <= '0;
      offset_q    <= '0;
      count_q     <= '0;
      beat_q      <= '0;
      wrap_en_q   <= 1'b0;
      wrap_log2_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            rd_base_q   <= rd_base;
            wr_base_q   <= wr_base;
            stride_q    <= stride;
            step_q      <= stride * ADDR_W'(LANES);
            count_q     <= count;
            wrap_en_q   <= wrap_en;
            wrap_log2_q <= wrap_log2;
            offset_q    <= '0;
            beat_q      <= '0;
            busy        <= 1'b1;
            if (count != '0) begin
              state <= RUN;
              valid <= 1'b1;
            end else begin
              // Empty burst: go straight to the completion pulse.
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            // Cancel wins over a same-cycle handshake; no completion pulse.
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
          end else if (ready) begin
            if (beat_q == count_q - CNT_W'(1)) begin
              state <= DONE;
              valid <= 1'b0;
              done  <= 1'b1;
            end else begin
              beat_q   <= beat_q + CNT_W'(1);
              offset_q <= offset_q + step_q;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Window mask derived from the latched wrap configuration.
  always_comb begin
    mask = wrap_mask(wrap_en_q, wrap_log2_q);
  end

  // Per-lane addresses from registered state only. They therefore hold
  // whenever the offset and the latched bases are unchanged.
  always_comb begin
    rd_addr  = '0;
    wr_addr  = '0;
    lane_off = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_off = (offset_q + ADDR_W'(i) * stride_q) & mask;
      rd_addr[i*ADDR_W +: ADDR_W] = rd_base_q + lane_off;
      wr_addr[i*ADDR_W +: ADDR_W] = wr_base_q + lane_off;
    end
  end

endmodule

// File: tb/tb_burst_addr_gen.sv
// Testbench for burst_addr_gen: directed bursts. Each expected beat is queued
// when its burst is issued, and a monitor pops the queue on every handshake.
module tb_burst_addr_gen;
  localparam int ADDR_W  = 32;
  localparam int LANES   = 16;
  localparam int CNT_W   = 16;
  localparam int WRAP_LW = 5;
  localparam int VW      = LANES*ADDR_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               abort;
  logic [ADDR_W-1:0]  rd_base;
  logic [ADDR_W-1:0]  wr_base;
  logic [ADDR_W-1:0]  stride;
  logic [CNT_W-1:0]   count;
  logic               wrap_en;
  logic [WRAP_LW-1:0] wrap_log2;
  logic               ready;
  logic               valid;
  logic [VW-1:0]      rd_addr;
  logic [VW-1:0]      wr_addr;
  logic               busy;
  logic               done;

  int total = 0;
  int bad   = 0;
  int acc   = 0;
  logic [VW-1:0] exp_rd[$];
  logic [VW-1:0] exp_wr[$];

  burst_addr_gen #(.ADDR_W(ADDR_W), .LANES(LANES), .CNT_W(CNT_W), .WRAP_LW(WRAP_LW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .rd_base(rd_base), .wr_base(wr_base), .stride(stride), .count(count),
    .wrap_en(wrap_en), .wrap_log2(wrap_log2), .ready(ready),
    .valid(valid), .rd_addr(rd_addr), .wr_addr(wr_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Queue one expected beat: lane i = first + i*step (ADDR_W truncation).
  task automatic push_beat(input logic [ADDR_W-1:0] rd0, input logic [ADDR_W-1:0] wr0,
                           input logic [ADDR_W-1:0] step);
    logic [VW-1:0] r, w;
    for (int i = 0; i < LANES; i++) begin
      r[i*ADDR_W +: ADDR_W] = rd0 + ADDR_W'(i) * step;
      w[i*ADDR_W +: ADDR_W] = wr0 + ADDR_W'(i) * step;
    end
    exp_rd.push_back(r);
    exp_wr.push_back(w);
  endtask

  // One-cycle start pulse; returns 1ns into the cycle after the accepting edge.
  task automatic issue_start(input logic [ADDR_W-1:0] rb, input logic [ADDR_W-1:0] wb,
                             input logic [ADDR_W-1:0] st, input logic [CNT_W-1:0] cnt,
                             input logic we, input logic [WRAP_LW-1:0] wl);
    @(posedge clk); #1;
    rd_base = rb; wr_base = wb; stride = st; count = cnt;
    wrap_en = we; wrap_log2 = wl; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Bounded wait for the done pulse; ends on the negedge where done is seen.
  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    chk(nm, 64'(seen), 64'd1);
  endtask

  // Scoreboard monitor: every accepted (non-aborted) beat must match the queue head.
  always @(negedge clk) begin
    if (!rst && valid && ready && !abort) begin
      acc++;
      if (exp_rd.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_beat: got a beat rd lane0=0x%0h expected none", rd_addr[ADDR_W-1:0]);
      end else begin
        chk_vec("beat_rd", rd_addr, exp_rd.pop_front());
        chk_vec("beat_wr", wr_addr, exp_wr.pop_front());
      end
    end
  end

  initial begin
    int a0;
    bit saw;
    rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b1;
    rd_base = '0; wr_base = '0; stride = '0; count = '0; wrap_en = 1'b0; wrap_log2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_busy",  64'(busy),  64'd0);
    chk("rst_done",  64'(done),  64'd0);
    chk_vec("rst_rd", rd_addr, '0);
    chk_vec("rst_wr", wr_addr, '0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: basic burst with explicit cycle timing
    push_beat(32'h100, 32'h2000, 32'd1);
    push_beat(32'h110, 32'h2010, 32'd1);
    issue_start(32'h100, 32'h2000, 32'd1, 16'd2, 1'b0, 5'd0);
    @(negedge clk);
    chk("s1_valid_b0", 64'(valid), 64'd1);
    chk("s1_busy_b0",  64'(busy),  64'd1);
    @(negedge clk);
    chk("s1_valid_b1", 64'(valid), 64'd1);
    @(negedge clk);
    chk("s1_done",       64'(done),  64'd1);
    chk("s1_valid_done", 64'(valid), 64'd0);
    chk("s1_busy_done",  64'(busy),  64'd1);
    @(negedge clk);
    chk("s1_done_clear", 64'(done), 64'd0);
    chk("s1_busy_clear", 64'(busy), 64'd0);
    chk("s1_rd_hold", 64'(rd_addr[ADDR_W-1:0]), 64'h110);

    // 2: backpressure during beat 0
    a0 = acc;
    ready = 1'b0;
    push_beat(32'h100, 32'h2000, 32'd1);
    push_beat(32'h110, 32'h2010, 32'd1);
    issue_start(32'h100, 32'h2000, 32'd1, 16'd2, 1'b0, 5'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("s2_valid_stall", 64'(valid), 64'd1);
      chk("s2_lane0_stall", 64'(rd_addr[0 +: ADDR_W]), 64'h100);
      chk("s2_lane15_stall", 64'(rd_addr[15*ADDR_W +: ADDR_W]), 64'h10F);
    end
    @(posedge clk); #1 ready = 1'b1;
    wait_done("s2_done_seen");
    chk("s2_beats", 64'(acc - a0), 64'd2);

    // 3: circular addressing, 32-word window
    push_beat(32'h1000, 32'h3000, 32'd1);
    push_beat(32'h1010, 32'h3010, 32'd1);
    push_beat(32'h1000, 32'h3000, 32'd1);
    issue_start(32'h1000, 32'h3000, 32'd1, 16'd3, 1'b1, 5'd5);
    wait_done("s3_done_seen");

    // 4: address overflow, then stride 4
    push_beat(32'hFFFF_FFF8, 32'h0, 32'd1);
    issue_start(32'hFFFF_FFF8, 32'h0, 32'd1, 16'd1, 1'b0, 5'd0);
    @(negedge clk);
    chk("s4_lane7", 64'(rd_addr[7*ADDR_W +: ADDR_W]), 64'hFFFF_FFFF);
    chk("s4_lane8", 64'(rd_addr[8*ADDR_W +: ADDR_W]), 64'h0);
    wait_done("s4a_done_seen");
    push_beat(32'h0,  32'h500, 32'd4);
    push_beat(32'h40, 32'h540, 32'd4);
    issue_start(32'h0, 32'h500, 32'd4, 16'd2, 1'b0, 5'd0);
    wait_done("s4b_done_seen");

    // 5a: zero-count burst
    a0 = acc;
    issue_start(32'h777, 32'h888, 32'd1, 16'd0, 1'b0, 5'd0);
    @(negedge clk);
    chk("s5_zero_done",  64'(done),  64'd1);
    chk("s5_zero_valid", 64'(valid), 64'd0);
    @(negedge clk);
    chk("s5_zero_done_clear", 64'(done), 64'd0);
    chk("s5_zero_beats", 64'(acc - a0), 64'd0);

    // 5b: start pulsed during RUN is ignored
    a0 = acc;
    for (int b = 0; b < 4; b++)
      push_beat(32'h200 + 32'(b*32), 32'h4000 + 32'(b*32), 32'd2);
    issue_start(32'h200, 32'h4000, 32'd2, 16'd4, 1'b0, 5'd0);
    rd_base = 32'h9999; count = 16'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("s5_run_done_seen");
    saw = 0;
    repeat (5) begin
      @(negedge clk);
      if (valid) saw = 1;
    end
    chk("s5_no_second_burst", 64'(saw), 64'd0);
    chk("s5_run_beats", 64'(acc - a0), 64'd4);

    // 6a: abort during beat 2 of 5
    a0 = acc;
    push_beat(32'h300, 32'h600, 32'd1);
    push_beat(32'h310, 32'h610, 32'd1);
    issue_start(32'h300, 32'h600, 32'd1, 16'd5, 1'b0, 5'd0);
    @(posedge clk); #1;
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("s6_abort_valid", 64'(valid), 64'd0);
    chk("s6_abort_busy",  64'(busy),  64'd0);
    saw = 0;
    if (done) saw = 1;
    repeat (3) begin
      @(negedge clk);
      if (done) saw = 1;
    end
    chk("s6_abort_no_done", 64'(saw), 64'd0);
    chk("s6_abort_beats", 64'(acc - a0), 64'd2);

    // 6b: asynchronous reset mid-burst
    ready = 1'b0;
    issue_start(32'hABC0, 32'hDEF0, 32'd3, 16'd5, 1'b0, 5'd0);
    @(negedge clk);
    chk("s6_pre_rst_valid", 64'(valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("s6_rst_valid", 64'(valid), 64'd0);
    chk("s6_rst_busy",  64'(busy),  64'd0);
    chk("s6_rst_done",  64'(done),  64'd0);
    chk_vec("s6_rst_rd", rd_addr, '0);
    chk_vec("s6_rst_wr", wr_addr, '0);
    @(posedge clk); #1 rst = 1'b0; ready = 1'b1;

    // 6c: fresh burst after reset
    push_beat(32'h800, 32'h900, 32'd1);
    push_beat(32'h810, 32'h910, 32'd1);
    issue_start(32'h800, 32'h900, 32'd1, 16'd2, 1'b0, 5'd0);
    wait_done("s6_fresh_done_seen");
    @(negedge clk);
    chk("sb_empty", 64'(exp_rd.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
